// File: rtl/uart_program_loader_pkg.sv
// Shared definitions for the UART program loader: FSM encoding, frame markers
// and memory geometry.
package uart_program_loader_pkg;

    localparam int ROM_DEPTH = 14;
    localparam int ISA_WIDTH = 32;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;
    localparam logic [7:0] TGT_INSTR = 8'h00;
    localparam logic [7:0] TGT_DATA  = 8'h01;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE    = 3'd0;
    localparam state_t ST_TARGET  = 3'd1;
    localparam state_t ST_LEN_LO  = 3'd2;
    localparam state_t ST_LEN_HI  = 3'd3;
    localparam state_t ST_PAYLOAD = 3'd4;
    localparam state_t ST_CHECK   = 3'd5;

endpackage

// File: rtl/uart_program_loader_if.sv
// Upload write bus between the loader (master) and the instruction/data
// memories plus hazard unit (slave).
interface uart_program_loader_if #(
    parameter int ROM_DEPTH = 14,
    parameter int ISA_WIDTH = 32
);
    logic                 upg_wen_o;
    logic [ROM_DEPTH:0]   upg_adr_o;
    logic [ISA_WIDTH-1:0] upg_dat_o;
    logic                 upg_done_o;

    modport master (output upg_wen_o, output upg_adr_o, output upg_dat_o, output upg_done_o);
    modport slave  (input  upg_wen_o, input  upg_adr_o, input  upg_dat_o, input  upg_done_o);
endinterface

// File: rtl/uart_word_assembler.sv
// Little-endian byte-to-word packer with running XOR checksum over every
// accepted payload byte.
module uart_word_assembler #(
    parameter int ISA_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr_i,
    input  logic                 en_i,
    input  logic [7:0]           byte_i,
    output logic [ISA_WIDTH-1:0] word_o,
    output logic                 ready_o,
    output logic [7:0]           chk_o
);
    localparam int NB = ISA_WIDTH / 8;
    localparam int KW = (NB > 1) ? $clog2(NB) : 1;

    logic [ISA_WIDTH-1:0] word_q, word_d, merged;
    logic [KW-1:0]        k_q, k_d;
    logic [7:0]           chk_q, chk_d;

    // Word including the byte on the input, so the final byte can be
    // written out on the same edge that accepts it.
    always_comb begin
        merged = word_q;
        merged[{k_q, 3'b000} +: 8] = byte_i;
    end

    always_comb begin
        word_d = word_q;
        k_d    = k_q;
        chk_d  = chk_q;
        if (clr_i) begin
            word_d = '0;
            k_d    = '0;
            chk_d  = '0;
        end else if (en_i) begin
            word_d = merged;
            k_d    = k_q + KW'(1);
            chk_d  = chk_q ^ byte_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            word_q <= '0;
            k_q    <= '0;
            chk_q  <= '0;
        end else begin
            word_q <= word_d;
            k_q    <= k_d;
            chk_q  <= chk_d;
        end
    end

    assign word_o  = merged;
    assign ready_o = en_i && (k_q == KW'(NB - 1));
    assign chk_o   = chk_q;

endmodule

// File: rtl/uart_program_loader.sv
// Parses SYNC/TARGET/LEN/payload/CHK upload frames from the UART byte stream
// and writes assembled words into instruction or data memory.
module uart_program_loader #(
    parameter int         ROM_DEPTH      = uart_program_loader_pkg::ROM_DEPTH,
    parameter int         ISA_WIDTH      = uart_program_loader_pkg::ISA_WIDTH,
    parameter logic [7:0] SYNC_BYTE      = uart_program_loader_pkg::SYNC_BYTE,
    parameter int         TIMEOUT_CYCLES = 1_000_000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rx_valid,
    input  logic [7:0]            rx_byte,
    input  logic                  upload_en,
    uart_program_loader_if.master upg,
    output logic                  busy_o,
    output logic                  error_o
);
    import uart_program_loader_pkg::*;

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    state_t               state_q, state_d;
    logic                 tgt_q, tgt_d;
    logic [7:0]           len_lo_q, len_lo_d;
    logic [15:0]          len_q, len_d;
    logic [ROM_DEPTH-1:0] idx_q, idx_d;
    logic [TW-1:0]        tmo_q, tmo_d;
    logic                 wen_q, wen_d, done_q, done_d, err_q, err_d;
    logic [ROM_DEPTH:0]   adr_q, adr_d;
    logic [ISA_WIDTH-1:0] dat_q, dat_d;

    logic                 abort, fail, done_ev, sync_acc, byte_ok;
    logic                 len_bad, last_word, asm_en, word_ready;
    logic [15:0]          len_rx;
    logic [ISA_WIDTH-1:0] word_full;
    logic [7:0]           chk;

    // A byte arriving in the expiry cycle keeps the frame alive.
    always_comb begin
        abort = 1'b0;
        if (state_q != ST_IDLE)
            abort = !upload_en || (!rx_valid && (tmo_q == TW'(TIMEOUT_CYCLES - 1)));
    end

    assign byte_ok   = rx_valid && !abort;
    assign sync_acc  = (state_q == ST_IDLE) && rx_valid && upload_en && (rx_byte == SYNC_BYTE);
    assign len_rx    = {rx_byte, len_lo_q};
    assign len_bad   = (len_rx == 16'd0) || (32'(len_rx) > (32'd1 << ROM_DEPTH));
    assign last_word = (32'(idx_q) == 32'(len_q) - 32'd1);
    assign asm_en    = byte_ok && (state_q == ST_PAYLOAD);

    uart_word_assembler #(.ISA_WIDTH(ISA_WIDTH)) u_asm (
        .clk     (clk),
        .rst     (rst),
        .clr_i   (sync_acc),
        .en_i    (asm_en),
        .byte_i  (rx_byte),
        .word_o  (word_full),
        .ready_o (word_ready),
        .chk_o   (chk)
    );

    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        fail    = 1'b0;
        done_ev = 1'b0;
        if (abort) begin
            state_d = ST_IDLE;
            fail    = 1'b1;
        end else if (rx_valid) begin
            case (state_q)
                ST_IDLE:    if (sync_acc) state_d = ST_TARGET;
                ST_TARGET: begin
                    if (rx_byte == TGT_INSTR || rx_byte == TGT_DATA) state_d = ST_LEN_LO;
                    else begin state_d = ST_IDLE; fail = 1'b1; end
                end
                ST_LEN_LO:  state_d = ST_LEN_HI;
                ST_LEN_HI: begin
                    if (len_bad) begin state_d = ST_IDLE; fail = 1'b1; end
                    else state_d = ST_PAYLOAD;
                end
                ST_PAYLOAD: if (word_ready && last_word) state_d = ST_CHECK;
                ST_CHECK: begin
                    state_d = ST_IDLE;
                    if (rx_byte == chk) done_ev = 1'b1;
                    else fail = 1'b1;
                end
                default:    state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        wen_d    = word_ready;
        adr_d    = adr_q;
        dat_d    = dat_q;
        idx_d    = idx_q;
        tgt_d    = tgt_q;
        len_lo_d = len_lo_q;
        len_d    = len_q;
        if (word_ready) begin
            adr_d = {tgt_q, idx_q};
            dat_d = word_full;
            idx_d = idx_q + ROM_DEPTH'(1);
        end
        if (sync_acc) idx_d = '0;
        if (byte_ok && state_q == ST_TARGET) tgt_d    = rx_byte[0];
        if (byte_ok && state_q == ST_LEN_LO) len_lo_d = rx_byte;
        if (byte_ok && state_q == ST_LEN_HI) len_d    = len_rx;
        tmo_d  = (rx_valid || state_q == ST_IDLE) ? '0 : tmo_q + TW'(1);
        done_d = done_ev;
        err_d  = fail ? 1'b1 : (sync_acc ? 1'b0 : err_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tgt_q    <= 1'b0;
            len_lo_q <= '0;
            len_q    <= '0;
            idx_q    <= '0;
            tmo_q    <= '0;
            wen_q    <= 1'b0;
            adr_q    <= '0;
            dat_q    <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            tgt_q    <= tgt_d;
            len_lo_q <= len_lo_d;
            len_q    <= len_d;
            idx_q    <= idx_d;
            tmo_q    <= tmo_d;
            wen_q    <= wen_d;
            adr_q    <= adr_d;
            dat_q    <= dat_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    assign upg.upg_wen_o  = wen_q;
    assign upg.upg_adr_o  = adr_q;
    assign upg.upg_dat_o  = dat_q;
    assign upg.upg_done_o = done_q;
    assign busy_o         = (state_q != ST_IDLE);
    assign error_o        = err_q;

endmodule

// File: tb/tb_uart_program_loader.sv
// Directed bench for the UART program loader: frame parsing, write strobes,
// checksum, error paths, timeout and reset behaviour.
module tb_uart_program_loader;
    localparam int RD  = 14;
    localparam int IW  = 32;
    localparam int TMO = 16;

    logic       clk       = 1'b0;
    logic       rst       = 1'b1;
    logic       rx_valid  = 1'b0;
    logic [7:0] rx_byte   = 8'h00;
    logic       upload_en = 1'b1;
    logic       busy, err;

    int n_checks = 0;
    int n_fail   = 0;
    int done_cnt = 0;
    logic [RD:0]   wr_adr[$];
    logic [IW-1:0] wr_dat[$];

    uart_program_loader_if #(.ROM_DEPTH(RD), .ISA_WIDTH(IW)) bus ();

    uart_program_loader #(
        .ROM_DEPTH(RD), .ISA_WIDTH(IW), .SYNC_BYTE(8'hA5), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rx_valid  (rx_valid),
        .rx_byte   (rx_byte),
        .upload_en (upload_en),
        .upg       (bus.master),
        .busy_o    (busy),
        .error_o   (err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.upg_wen_o) begin
            wr_adr.push_back(bus.upg_adr_o);
            wr_dat.push_back(bus.upg_dat_o);
        end
        if (bus.upg_done_o) done_cnt++;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_byte  = b;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic clear_log();
        wr_adr.delete();
        wr_dat.delete();
        done_cnt = 0;
    endtask

    // Payload 78 56 34 12 EF BE AD DE XORs to 8'h2A.
    task automatic send_two_word_frame(input logic [7:0] tgt, input logic [7:0] chk);
        send(8'hA5); send(tgt); send(8'h02); send(8'h00);
        send(8'h78); send(8'h56); send(8'h34); send(8'h12);
        send(8'hEF); send(8'hBE); send(8'hAD); send(8'hDE);
        send(chk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(3);
        n_checks++; if (bus.upg_wen_o !== 1'b0) begin n_fail++; $display("FAIL rst_wen: got %b want 0", bus.upg_wen_o); end
        n_checks++; if (bus.upg_adr_o !== 15'h0) begin n_fail++; $display("FAIL rst_adr: got %h want 0", bus.upg_adr_o); end
        n_checks++; if (bus.upg_dat_o !== 32'h0) begin n_fail++; $display("FAIL rst_dat: got %h want 0", bus.upg_dat_o); end
        n_checks++; if (bus.upg_done_o !== 1'b0) begin n_fail++; $display("FAIL rst_done: got %b want 0", bus.upg_done_o); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b want 0", busy); end
        n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL rst_err: got %b want 0", err); end
        rst = 1'b0;
        tick(1);
    endtask

    task automatic test_instr_frame();
        clear_log();
        send(8'hA5);
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL instr_busy: got %b want 1", busy); end
        send(8'h00); send(8'h02); send(8'h00);
        send(8'h78); send(8'h56); send(8'h34);
        n_checks++; if (bus.upg_wen_o !== 1'b0) begin n_fail++; $display("FAIL instr_early_wen: got %b want 0", bus.upg_wen_o); end
        send(8'h12);
        n_checks++; if (bus.upg_wen_o !== 1'b1) begin n_fail++; $display("FAIL instr_wr0_strobe: got %b want 1", bus.upg_wen_o); end
        n_checks++; if (bus.upg_adr_o !== 15'h0000) begin n_fail++; $display("FAIL instr_wr0_adr: got %h want 0000", bus.upg_adr_o); end
        n_checks++; if (bus.upg_dat_o !== 32'h12345678) begin n_fail++; $display("FAIL instr_wr0_dat: got %h want 12345678", bus.upg_dat_o); end
        send(8'hEF);
        n_checks++; if (bus.upg_wen_o !== 1'b0) begin n_fail++; $display("FAIL instr_wr0_single: got %b want 0", bus.upg_wen_o); end
        n_checks++; if (bus.upg_dat_o !== 32'h12345678) begin n_fail++; $display("FAIL instr_dat_hold: got %h want 12345678", bus.upg_dat_o); end
        send(8'hBE); send(8'hAD); send(8'hDE);
        n_checks++; if (bus.upg_wen_o !== 1'b1) begin n_fail++; $display("FAIL instr_wr1_strobe: got %b want 1", bus.upg_wen_o); end
        n_checks++; if (bus.upg_adr_o !== 15'h0001) begin n_fail++; $display("FAIL instr_wr1_adr: got %h want 0001", bus.upg_adr_o); end
        n_checks++; if (bus.upg_dat_o !== 32'hDEADBEEF) begin n_fail++; $display("FAIL instr_wr1_dat: got %h want deadbeef", bus.upg_dat_o); end
        send(8'h2A);
        n_checks++; if (bus.upg_done_o !== 1'b1) begin n_fail++; $display("FAIL instr_done: got %b want 1", bus.upg_done_o); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL instr_idle: got %b want 0", busy); end
        n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL instr_err: got %b want 0", err); end
        tick(1);
        n_checks++; if (bus.upg_done_o !== 1'b0) begin n_fail++; $display("FAIL instr_done_pulse: got %b want 0", bus.upg_done_o); end
        tick(2);
        n_checks++; if (wr_adr.size() !== 2) begin n_fail++; $display("FAIL instr_wr_count: got %0d want 2", wr_adr.size()); end
        n_checks++; if (done_cnt !== 1) begin n_fail++; $display("FAIL instr_done_count: got %0d want 1", done_cnt); end
    endtask

    task automatic test_data_frame();
        clear_log();
        send_two_word_frame(8'h01, 8'h2A);
        tick(2);
        n_checks++; if (wr_adr.size() !== 2) begin n_fail++; $display("FAIL data_wr_count: got %0d want 2", wr_adr.size()); end
        if (wr_adr.size() == 2) begin
            n_checks++; if (wr_adr[0] !== 15'h4000) begin n_fail++; $display("FAIL data_adr0: got %h want 4000", wr_adr[0]); end
            n_checks++; if (wr_adr[1] !== 15'h4001) begin n_fail++; $display("FAIL data_adr1: got %h want 4001", wr_adr[1]); end
            n_checks++; if (wr_dat[0] !== 32'h12345678) begin n_fail++; $display("FAIL data_dat0: got %h want 12345678", wr_dat[0]); end
            n_checks++; if (wr_dat[1] !== 32'hDEADBEEF) begin n_fail++; $display("FAIL data_dat1: got %h want deadbeef", wr_dat[1]); end
        end
        n_checks++; if (done_cnt !== 1) begin n_fail++; $display("FAIL data_done_count: got %0d want 1", done_cnt); end
        n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL data_err: got %b want 0", err); end
    endtask

    task automatic test_bad_checksum();
        clear_log();
        send_two_word_frame(8'h00, 8'h01);
        tick(2);
        n_checks++; if (wr_adr.size() !== 2) begin n_fail++; $display("FAIL badchk_wr_count: got %0d want 2", wr_adr.size()); end
        n_checks++; if (done_cnt !== 0) begin n_fail++; $display("FAIL badchk_done_count: got %0d want 0", done_cnt); end
        n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL badchk_err: got %b want 1", err); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL badchk_idle: got %b want 0", busy); end
        send(8'hA5);
        n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL badchk_sync_clears: got %b want 0", err); end
        send(8'h02);
        n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL badchk_bad_target: got %b want 1", err); end
    endtask

    task automatic test_bad_header();
        clear_log();
        send(8'hA5); send(8'h02);
        n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL hdr_target_err: got %b want 1", err); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL hdr_target_idle: got %b want 0", busy); end
        send(8'hA5); send(8'h00); send(8'h00); send(8'h00);
        n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL hdr_len0_err: got %b want 1", err); end
        send(8'hA5); send(8'h00); send(8'h01); send(8'h40);
        n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL hdr_len_over_err: got %b want 1", err); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL hdr_len_over_idle: got %b want 0", busy); end
        send(8'hA5); send(8'h01); send(8'h00); send(8'h40);
        n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL hdr_len_max_err: got %b want 0", err); end
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL hdr_len_max_busy: got %b want 1", busy); end
        upload_en = 1'b0;
        tick(1);
        n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL hdr_abort_err: got %b want 1", err); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL hdr_abort_idle: got %b want 0", busy); end
        upload_en = 1'b1;
        tick(1);
        n_checks++; if (wr_adr.size() !== 0) begin n_fail++; $display("FAIL hdr_no_writes: got %0d want 0", wr_adr.size()); end
    endtask

    task automatic test_timeout();
        clear_log();
        send(8'hA5); send(8'h00); send(8'h01); send(8'h00); send(8'h11);
        tick(TMO - 1);
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL tmo_not_early: got %b want 1", busy); end
        send(8'h22);
        n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL tmo_byte_wins_err: got %b want 0", err); end
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL tmo_byte_wins_busy: got %b want 1", busy); end
        tick(10);
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL tmo_restart_busy: got %b want 1", busy); end
        tick(10);
        n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL tmo_err: got %b want 1", err); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL tmo_idle: got %b want 0", busy); end
        n_checks++; if (wr_adr.size() !== 0) begin n_fail++; $display("FAIL tmo_no_writes: got %0d want 0", wr_adr.size()); end
    endtask

    task automatic test_upload_en_drop();
        send(8'hA5); send(8'h00); send(8'h02);
        n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL drop_pre_err: got %b want 0", err); end
        upload_en = 1'b0;
        tick(1);
        n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL drop_err: got %b want 1", err); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL drop_idle: got %b want 0", busy); end
        upload_en = 1'b1;
    endtask

    task automatic test_disabled();
        upload_en = 1'b0;
        send(8'hA5);
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL dis_busy: got %b want 0", busy); end
        n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL dis_err_kept: got %b want 1", err); end
        send(8'h00);
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL dis_busy2: got %b want 0", busy); end
        upload_en = 1'b1;
        tick(1);
    endtask

    task automatic test_rst_midframe();
        clear_log();
        send(8'hA5); send(8'h00); send(8'h01); send(8'h00);
        send(8'h11); send(8'h22); send(8'h33);
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL rstmid_busy: got %b want 1", busy); end
        rx_valid = 1'b1;
        rx_byte  = 8'h44;
        rst      = 1'b1;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
        rst      = 1'b0;
        n_checks++; if (bus.upg_wen_o !== 1'b0) begin n_fail++; $display("FAIL rstmid_wen: got %b want 0", bus.upg_wen_o); end
        n_checks++; if (bus.upg_adr_o !== 15'h0) begin n_fail++; $display("FAIL rstmid_adr: got %h want 0", bus.upg_adr_o); end
        n_checks++; if (bus.upg_dat_o !== 32'h0) begin n_fail++; $display("FAIL rstmid_dat: got %h want 0", bus.upg_dat_o); end
        n_checks++; if (bus.upg_done_o !== 1'b0) begin n_fail++; $display("FAIL rstmid_done: got %b want 0", bus.upg_done_o); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy_after: got %b want 0", busy); end
        n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL rstmid_err: got %b want 0", err); end
        tick(2);
        n_checks++; if (wr_adr.size() !== 0) begin n_fail++; $display("FAIL rstmid_no_write: got %0d want 0", wr_adr.size()); end
    endtask

    task automatic test_back_to_back();
        clear_log();
        send_two_word_frame(8'h00, 8'h2A);
        send_two_word_frame(8'h01, 8'h2A);
        tick(2);
        n_checks++; if (wr_adr.size() !== 4) begin n_fail++; $display("FAIL b2b_wr_count: got %0d want 4", wr_adr.size()); end
        if (wr_adr.size() == 4) begin
            n_checks++; if (wr_adr[1] !== 15'h0001) begin n_fail++; $display("FAIL b2b_adr1: got %h want 0001", wr_adr[1]); end
            n_checks++; if (wr_adr[2] !== 15'h4000) begin n_fail++; $display("FAIL b2b_adr2: got %h want 4000", wr_adr[2]); end
            n_checks++; if (wr_dat[3] !== 32'hDEADBEEF) begin n_fail++; $display("FAIL b2b_dat3: got %h want deadbeef", wr_dat[3]); end
        end
        n_checks++; if (done_cnt !== 2) begin n_fail++; $display("FAIL b2b_done_count: got %0d want 2", done_cnt); end
        n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL b2b_err: got %b want 0", err); end
    endtask

    initial begin
        @(posedge clk);
        #1;
        test_reset();
        test_instr_frame();
        test_data_frame();
        test_bad_checksum();
        test_bad_header();
        test_timeout();
        test_upload_en_drop();
        test_disabled();
        test_rst_midframe();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no end of test, want finish within time limit");
        $fatal(1);
    end

endmodule
